// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared state encoding, screen geometry and clamp limits for the ball sequencer
package ball_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_X = 2'd1,
        CALC_Y = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int BALL_SIZE = 20;
    localparam int INIT_X    = 320;
    localparam int INIT_Y    = 240;

    localparam logic [9:0] X_MIN = 10'(BALL_SIZE);
    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0] Y_MIN = 10'(BALL_SIZE);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - BALL_SIZE);

endpackage

// File: rtl/axis_step.sv
// rtl/axis_step.sv - combinational clamp-and-reverse step for one axis
module axis_step (
    input  logic [9:0] pos,
    input  logic       dir,
    input  logic [2:0] step,
    input  logic [9:0] pos_min,
    input  logic [9:0] pos_max,
    output logic [9:0] next_pos,
    output logic       next_dir,
    output logic       rev
);

    logic [10:0] sum;
    logic [10:0] diff;
    logic [10:0] min_plus_step;

    // 11-bit arithmetic so the right edge sum cannot wrap and the left edge test never underflows
    assign sum           = {1'b0, pos} + {8'd0, step};
    assign diff          = {1'b0, pos} - {8'd0, step};
    assign min_plus_step = {1'b0, pos_min} + {8'd0, step};

    always_comb begin
        next_pos = pos;
        next_dir = dir;
        rev      = 1'b0;
        if (dir) begin
            if (sum >= {1'b0, pos_max}) begin
                next_pos = pos_max;
                next_dir = 1'b0;
                rev      = 1'b1;
            end else begin
                next_pos = sum[9:0];
            end
        end else begin
            if (({1'b0, pos} < min_plus_step) || (diff <= {1'b0, pos_min})) begin
                next_pos = pos_min;
                next_dir = 1'b1;
                rev      = 1'b1;
            end else begin
                next_pos = diff[9:0];
            end
        end
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - per-frame ball motion sequencer with atomic X/Y commit and bounce events
module ball_motion_ctrl
    import ball_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       pause,
    input  logic [2:0] speed,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       busy,
    output logic       update_done,
    output logic       bounce,
    output logic       corner,
    output logic [7:0] bounce_count,
    output logic       overrun
);

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [9:0] next_x_q, next_x_d, next_y_q, next_y_d;
    logic       ndir_x_q, ndir_x_d, ndir_y_q, ndir_y_d;
    logic       rev_x_q, rev_x_d, rev_y_q, rev_y_d;
    logic       busy_q, busy_d;
    logic       update_done_q, update_done_d;
    logic       bounce_q, bounce_d;
    logic       corner_q, corner_d;
    logic [7:0] bounce_count_q, bounce_count_d;
    logic       overrun_q, overrun_d;

    logic       use_y;
    logic [9:0] as_pos, as_min, as_max, as_next_pos;
    logic       as_dir, as_next_dir, as_rev;

    // One add/sub unit, steered to the Y operands only during CALC_Y
    assign use_y  = (state_q == CALC_Y);
    assign as_pos = use_y ? ball_y_q : ball_x_q;
    assign as_dir = use_y ? dir_y_q  : dir_x_q;
    assign as_min = use_y ? Y_MIN    : X_MIN;
    assign as_max = use_y ? Y_MAX    : X_MAX;

    axis_step u_axis_step (
        .pos      (as_pos),
        .dir      (as_dir),
        .step     (step_q),
        .pos_min  (as_min),
        .pos_max  (as_max),
        .next_pos (as_next_pos),
        .next_dir (as_next_dir),
        .rev      (as_rev)
    );

    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        ball_x_d       = ball_x_q;
        ball_y_d       = ball_y_q;
        dir_x_d        = dir_x_q;
        dir_y_d        = dir_y_q;
        next_x_d       = next_x_q;
        next_y_d       = next_y_q;
        ndir_x_d       = ndir_x_q;
        ndir_y_d       = ndir_y_q;
        rev_x_d        = rev_x_q;
        rev_y_d        = rev_y_q;
        update_done_d  = 1'b0;
        bounce_d       = 1'b0;
        corner_d       = 1'b0;
        bounce_count_d = bounce_count_q;
        overrun_d      = overrun_q;

        if (frame_start && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (frame_start && !pause) begin
                    step_d  = speed;
                    state_d = CALC_X;
                end
            end
            CALC_X: begin
                next_x_d = as_next_pos;
                ndir_x_d = as_next_dir;
                rev_x_d  = as_rev;
                state_d  = CALC_Y;
            end
            CALC_Y: begin
                next_y_d = as_next_pos;
                ndir_y_d = as_next_dir;
                rev_y_d  = as_rev;
                // Event pulses are registered here so they line up with the COMMIT cycle
                update_done_d = 1'b1;
                bounce_d      = rev_x_q | as_rev;
                corner_d      = rev_x_q & as_rev;
                state_d       = COMMIT;
            end
            COMMIT: begin
                ball_x_d       = next_x_q;
                ball_y_d       = next_y_q;
                dir_x_d        = ndir_x_q;
                dir_y_d        = ndir_y_q;
                bounce_count_d = bounce_count_q + {7'd0, rev_x_q} + {7'd0, rev_y_q};
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            step_q         <= 3'd0;
            ball_x_q       <= 10'(INIT_X);
            ball_y_q       <= 10'(INIT_Y);
            dir_x_q        <= 1'b1;
            dir_y_q        <= 1'b1;
            next_x_q       <= 10'(INIT_X);
            next_y_q       <= 10'(INIT_Y);
            ndir_x_q       <= 1'b1;
            ndir_y_q       <= 1'b1;
            rev_x_q        <= 1'b0;
            rev_y_q        <= 1'b0;
            busy_q         <= 1'b0;
            update_done_q  <= 1'b0;
            bounce_q       <= 1'b0;
            corner_q       <= 1'b0;
            bounce_count_q <= 8'd0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            ball_x_q       <= ball_x_d;
            ball_y_q       <= ball_y_d;
            dir_x_q        <= dir_x_d;
            dir_y_q        <= dir_y_d;
            next_x_q       <= next_x_d;
            next_y_q       <= next_y_d;
            ndir_x_q       <= ndir_x_d;
            ndir_y_q       <= ndir_y_d;
            rev_x_q        <= rev_x_d;
            rev_y_q        <= rev_y_d;
            busy_q         <= busy_d;
            update_done_q  <= update_done_d;
            bounce_q       <= bounce_d;
            corner_q       <= corner_d;
            bounce_count_q <= bounce_count_d;
            overrun_q      <= overrun_d;
        end
    end

    assign ball_x       = ball_x_q;
    assign ball_y       = ball_y_q;
    assign dir_x        = dir_x_q;
    assign dir_y        = dir_y_q;
    assign busy         = busy_q;
    assign update_done  = update_done_q;
    assign bounce       = bounce_q;
    assign corner       = corner_q;
    assign bounce_count = bounce_count_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb/tb_ball_motion_ctrl.sv - randomized self-checking bench for ball_motion_ctrl against a behavioural model
module tb_ball_motion_ctrl;

    localparam int XMIN = 20;
    localparam int XMAX = 620;
    localparam int YMIN = 20;
    localparam int YMAX = 460;

    logic       clk;
    logic       reset;
    logic       frame_start;
    logic       pause;
    logic [2:0] speed;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       dir_x;
    logic       dir_y;
    logic       busy;
    logic       update_done;
    logic       bounce;
    logic       corner;
    logic [7:0] bounce_count;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: ball centre as plain integers, direction, event total, sticky overrun
    int mx, my, mcnt;
    bit mdx, mdy, mov;

    ball_motion_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .pause        (pause),
        .speed        (speed),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .dir_x        (dir_x),
        .dir_y        (dir_y),
        .busy         (busy),
        .update_done  (update_done),
        .bounce       (bounce),
        .corner       (corner),
        .bounce_count (bounce_count),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Signed-integer travel then clamp: overshoot past a wall is pulled back onto it
    function automatic void model_axis(input int pos, input bit dir, input int s, input int lo,
                                       input int hi, output int np, output bit nd, output bit rv);
        np = dir ? pos + s : pos - s;
        nd = dir;
        rv = 1'b0;
        if (dir && np >= hi) begin
            np = hi; nd = 1'b0; rv = 1'b1;
        end else if (!dir && np <= lo) begin
            np = lo; nd = 1'b1; rv = 1'b1;
        end
    endfunction

    task automatic model_reset();
        mx = 320; my = 240; mdx = 1'b1; mdy = 1'b1; mcnt = 0; mov = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_x"}, ball_x, mx);
        check({tag, "_y"}, ball_y, my);
        check({tag, "_dx"}, dir_x, mdx);
        check({tag, "_dy"}, dir_y, mdy);
        check({tag, "_cnt"}, bounce_count, mcnt);
        check({tag, "_ovr"}, overrun, mov);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge four cycles later
    task automatic run_frame(input int spd, input bit pz, output bit ob_bounce, output bit ob_corner);
        int nx, ny;
        bit ndx, ndy, rx, ry;
        frame_start = 1'b1; speed = 3'(spd); pause = pz;
        @(posedge clk); #1;
        frame_start = 1'b0; speed = 3'($urandom); pause = 1'($urandom);
        check("busy_n1", busy, !pz);
        @(posedge clk); #1;
        check("done_n2", update_done, 0);
        @(posedge clk); #1;
        if (pz) begin
            nx = mx; ny = my; ndx = mdx; ndy = mdy; rx = 1'b0; ry = 1'b0;
        end else begin
            model_axis(mx, mdx, spd, XMIN, XMAX, nx, ndx, rx);
            model_axis(my, mdy, spd, YMIN, YMAX, ny, ndy, ry);
        end
        check("done_n3", update_done, !pz);
        check("bounce_n3", bounce, rx | ry);
        check("corner_n3", corner, rx & ry);
        check("hold_x_n3", ball_x, mx);
        ob_bounce = bounce;
        ob_corner = corner;
        @(posedge clk); #1;
        mx = nx; my = ny; mdx = ndx; mdy = ndy;
        mcnt = (mcnt + int'(rx) + int'(ry)) % 256;
        check("busy_n4", busy, 0);
        check("done_n4", update_done, 0);
        check_state("frm");
    endtask

    initial begin
        bit b, c;
        int rem, spd;
        frame_start = 1'b0; pause = 1'b0; speed = 3'd0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_state("rst");
        check("rst_busy", busy, 0);
        check("rst_done", update_done, 0);
        check("rst_bounce", bounce, 0);
        check("rst_corner", corner, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // First move from the reset centre
        run_frame(2, 1'b0, b, c);
        check("first_x", ball_x, 322);
        check("first_y", ball_y, 242);
        check("first_bounce", b, 0);

        // Walk to x=618, then clamp onto the right wall
        while (mx < 618) run_frame(2, 1'b0, b, c);
        check("pre_edge_x", ball_x, 618);
        rem = mcnt;
        run_frame(4, 1'b0, b, c);
        check("edge_x", ball_x, 620);
        check("edge_dx", dir_x, 0);
        check("edge_bounce", b, 1);
        check("edge_cnt", bounce_count, (rem + 1) % 256);
        run_frame(4, 1'b0, b, c);
        check("edge_back_x", ball_x, 616);

        // Approach x=22 moving left, then a step of 7 must clamp, not wrap
        while (mx - 22 > 7) run_frame(7, 1'b0, b, c);
        rem = mx - 22;
        if (rem > 0) run_frame(rem, 1'b0, b, c);
        check("pre_left_x", ball_x, 22);
        check("pre_left_dx", dir_x, 0);
        run_frame(7, 1'b0, b, c);
        check("left_x", ball_x, 20);
        check("left_dx", dir_x, 1);

        // Pause freezes, next frame resumes
        run_frame(5, 1'b1, b, c);
        run_frame(0, 1'b1, b, c);
        run_frame(3, 1'b0, b, c);

        // Second frame_start while busy: single commit with the first speed, sticky overrun
        frame_start = 1'b1; speed = 3'd3; pause = 1'b0;
        @(posedge clk); #1;
        speed = 3'd6;
        check("ovr_busy", busy, 1);
        @(posedge clk); #1;
        frame_start = 1'b0;
        mov = 1'b1;
        check("ovr_flag", overrun, 1);
        @(posedge clk); #1;
        check("ovr_done", update_done, 1);
        begin
            int nx, ny;
            bit ndx, ndy, rx, ry;
            model_axis(mx, mdx, 3, XMIN, XMAX, nx, ndx, rx);
            model_axis(my, mdy, 3, YMIN, YMAX, ny, ndy, ry);
            mx = nx; my = ny; mdx = ndx; mdy = ndy;
            mcnt = (mcnt + int'(rx) + int'(ry)) % 256;
        end
        @(posedge clk); #1;
        check_state("ovr");
        check("ovr_done_n4", update_done, 0);
        @(posedge clk); #1;
        check("ovr_busy_n5", busy, 0);
        check("ovr_done_n5", update_done, 0);
        run_frame(1, 1'b0, b, c);

        // Reset in the middle of a sequence: immediate return to the reset centre
        frame_start = 1'b1; speed = 3'd5; pause = 1'b0;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_state("areset");
        check("areset_busy", busy, 0);
        check("areset_done", update_done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_done", update_done, 0);
        check_state("post_reset");

        // Speed 5 from the reset centre reaches the top-left corner exactly after 660 frames
        for (int i = 0; i < 660; i++) run_frame(5, 1'b0, b, c);
        check("corner_pulse", c, 1);
        check("corner_x", ball_x, 20);
        check("corner_y", ball_y, 20);
        check("corner_cnt", bounce_count, 14);

        // Long randomized run, enough travel to wrap bounce_count past 255
        for (int i = 0; i < 11500; i++) begin
            spd = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(6, 7);
            run_frame(spd, $urandom_range(0, 31) == 0, b, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
Per-frame motion sequencer for the bouncing-ball sprite in the VGA top level. On each frame-start pulse from the sync generator it latches the speed and pause configuration. It then runs a short multi-cycle FSM that computes the next X/Y position with edge clamping and direction reversal, and commits both coordinates atomically. The ball renderer reads `ball_x`/`ball_y`. Bounce and corner events feed the colour and effects logic.

Parameters:
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in pixels
- BALL_SIZE, 20, ball radius; the centre is kept within [BALL_SIZE, ACTIVE-BALL_SIZE]
- INIT_X, 320, reset X centre
- INIT_Y, 240, reset Y centre

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse, asserted at hpos==0 and vpos==0
- pause  in  1  freeze motion; sampled at frame_start
- speed  in  3  step in pixels per frame for both axes (0 = no motion); sampled at frame_start
- ball_x  out  10  committed X centre
- ball_y  out  10  committed Y centre
- dir_x  out  1  1 = moving right
- dir_y  out  1  1 = moving down
- busy  out  1  FSM not in IDLE
- update_done  out  1  one-cycle pulse in the COMMIT cycle
- bounce  out  1  one-cycle pulse in COMMIT if either axis reversed
- corner  out  1  one-cycle pulse in COMMIT if both axes reversed
- bounce_count  out  8  total reversal events; wraps at 255 -> 0
- overrun  out  1  sticky flag: frame_start arrived while busy

Behaviour:
- Reset (async, active-high) values:
  - ball_x = INIT_X, ball_y = INIT_Y, dir_x = 1, dir_y = 1.
  - FSM = IDLE. All pulses = 0, bounce_count = 0, overrun = 0, latched step = 0.
- Reset asserted mid-sequence aborts the update. No partial commit is visible.
- FSM states: IDLE -> CALC_X -> CALC_Y -> COMMIT -> IDLE. Each state lasts one cycle.
- IDLE:
  - frame_start with pause = 0: latch step = speed, go to CALC_X.
  - frame_start with pause = 1: stay in IDLE; outputs unchanged; no update_done.
- CALC_X and CALC_Y use one shared add/sub unit; results go to the next_x / next_y shadow registers.
- Per-axis rule, shown for X (Y is the same with V_ACTIVE):
  - Moving right: sum = ball_x + step, computed 11 bits wide. If sum >= H_ACTIVE-BALL_SIZE: next_x = H_ACTIVE-BALL_SIZE, the next dir_x = 0, and a reversal is flagged. Otherwise next_x = sum.
  - Moving left: if ball_x < BALL_SIZE + step, or ball_x - step <= BALL_SIZE: next_x = BALL_SIZE, the next dir_x = 1, and a reversal is flagged. Otherwise next_x = ball_x - step. This avoids 10-bit underflow.
  - Landing exactly on the limit counts as a reversal.
- step = 0: positions are unchanged. A centre already sitting on a limit still reverses and bounces.
- COMMIT:
  - ball_x, ball_y, dir_x and dir_y all update in this same cycle.
  - update_done = 1.
  - bounce = rev_x | rev_y, corner = rev_x & rev_y.
  - bounce_count increments by 1 per reversing axis (a corner adds 2), mod 256.
- Latency: frame_start at cycle N gives COMMIT at cycle N+3; new outputs are visible from N+4.
- frame_start while busy is ignored. The sequence in flight completes normally and overrun sets to 1. It clears only on reset.
- speed and pause changes between frame_starts have no effect until the next frame_start.
- Outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Package ball_pkg holds:
  - the state enum (IDLE, CALC_X, CALC_Y, COMMIT);
  - the constants H_ACTIVE, V_ACTIVE, BALL_SIZE, INIT_X, INIT_Y;
  - the limits X_MIN/X_MAX and Y_MIN/Y_MAX derived from them.
- One sub-module, axis_step: combinational clamp/reverse for a single axis.
  - Inputs: pos, dir, step, min, max.
  - Outputs: next_pos, next_dir, rev.
  - It is instantiated once and time-shared by CALC_X and CALC_Y.

Test Plan:
- Reset then one frame_start with speed=2, pause=0 -> at N+3, update_done=1; ball_x=322, ball_y=242, dir 1/1, bounce=0.
- Right-edge clamp:
  - preload ball_x=618 via frames, speed=4 -> COMMIT ball_x=620, dir_x=0, bounce=1, bounce_count+=1;
  - next frame -> ball_x=616.
- Left underflow guard: ball_x=22, dir_x=0, speed=7 -> ball_x=20, dir_x=1, no wrap to ~1000.
- Corner: drive both axes to limits in the same frame (e.g. x=618, y=458, speed=2) -> corner=1, bounce_count increases by 2. Also check that 255 wraps to 1 on a corner.
- pause=1 at frame_start -> no busy, no update_done, positions hold; with pause=0 the next frame resumes.
- frame_start again at N+1 -> overrun=1, a single commit at N+3. Asserting reset at N+2 instead -> outputs return to 320/240 immediately, asynchronously.
